// File: rtl/route_sched_if.sv
// route_sched_if: header FIFO, payload FIFO and output-port signals of the router.
// master = the scheduler (route_sched); slave = the surrounding FIFOs and ports.
interface route_sched_if;
  logic        hdr_empty;
  logic [15:0] hdr_data;
  logic        hdr_ren;
  logic        pay_empty;
  logic        pay_ren;
  logic [7:0]  port1_addr;
  logic [7:0]  port2_addr;
  logic [7:0]  port3_addr;
  logic [2:0]  port_rdy;
  logic [2:0]  port_wen;
  logic [2:0]  port_sel;
  logic        busy;
  logic        drop_pulse;
  logic        timeout;

  modport master (
    input  hdr_empty, hdr_data, pay_empty, port1_addr, port2_addr, port3_addr, port_rdy,
    output hdr_ren, pay_ren, port_wen, port_sel, busy, drop_pulse, timeout
  );

  modport slave (
    output hdr_empty, hdr_data, pay_empty, port1_addr, port2_addr, port3_addr, port_rdy,
    input  hdr_ren, pay_ren, port_wen, port_sel, busy, drop_pulse, timeout
  );
endinterface

// File: rtl/route_sched.sv
// route_sched: pops a header, routes its payload beats to the matching output
// port (port1 > port2 > port3), or flushes them when no port matches.
// Optional macro ROUTE_TIMEOUT_EN: abandon a packet after TMO_CYC consecutive
// not-ready cycles on the selected port and flush its remaining beats.
module route_sched #(
  parameter int TMO_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  route_sched_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_RD, S_DECODE, S_XFER, S_DRAIN, S_DROP
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_dest, r_cnt;
  logic [2:0] r_sel, r_wen, w_match;
  logic       r_drop_pulse;
  logic       w_hdr_ren, w_rdy_sel, w_cnt_nz;
  logic       w_xfer_pop, w_drop_pop, w_pay_ren, w_tmo_fire;

  if (TMO_CYC < 1 || TMO_CYC > 31) begin : g_tmo_range
    $error("route_sched: TMO_CYC out of range 1..31");
  end

  // Address match with fixed priority port1 > port2 > port3
  always_comb begin
    w_match = 3'b000;
    if (r_dest == bus.port1_addr)      w_match = 3'b001;
    else if (r_dest == bus.port2_addr) w_match = 3'b010;
    else if (r_dest == bus.port3_addr) w_match = 3'b100;
  end

  assign w_rdy_sel  = |(bus.port_rdy & r_sel);
  assign w_cnt_nz   = |r_cnt;
  assign w_xfer_pop = (r_state == S_XFER) && w_rdy_sel && !bus.pay_empty && w_cnt_nz;
  assign w_drop_pop = (r_state == S_DROP) && !bus.pay_empty && w_cnt_nz;
  assign w_pay_ren  = w_xfer_pop || w_drop_pop;

`ifdef ROUTE_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(TMO_CYC - 1);
  logic [4:0] r_wait;
  logic       r_timeout;
  logic       w_stall;

  // A stall only counts while data is waiting and the port refuses it
  assign w_stall    = (r_state == S_XFER) && !w_rdy_sel && !bus.pay_empty && w_cnt_nz;
  assign w_tmo_fire = w_stall && (r_wait == TMO_LAST);

  // Consecutive-stall counter; any pop or leaving XFER restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait    <= 5'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo_fire;
      if (r_state != S_XFER || w_xfer_pop || w_tmo_fire) r_wait <= 5'd0;
      else if (w_stall)                                   r_wait <= r_wait + 5'd1;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_tmo_fire  = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and header pop strobe
  always_comb begin
    w_next    = r_state;
    w_hdr_ren = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.hdr_empty) begin
          w_hdr_ren = 1'b1;
          w_next    = S_HDR_RD;
        end
      end
      S_HDR_RD: w_next = (bus.hdr_data[15:8] == 8'd0) ? S_IDLE : S_DECODE;
      S_DECODE: w_next = (w_match != 3'b000) ? S_XFER : S_DROP;
      S_XFER: begin
        if (w_tmo_fire)                         w_next = S_DROP;
        else if (w_xfer_pop && r_cnt == 8'd1)   w_next = S_DRAIN;
        else if (!w_cnt_nz)                     w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_IDLE;
      S_DROP: begin
        if (!w_cnt_nz || (w_drop_pop && r_cnt == 8'd1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Header latch, beat counter, port select and registered write enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dest       <= 8'd0;
      r_cnt        <= 8'd0;
      r_sel        <= 3'b000;
      r_wen        <= 3'b000;
      r_drop_pulse <= 1'b0;
    end else begin
      r_wen        <= w_xfer_pop ? r_sel : 3'b000;
      r_drop_pulse <= (w_next == S_DROP) && (r_state != S_DROP);
      if (r_state == S_HDR_RD) begin
        r_dest <= bus.hdr_data[7:0];
        r_cnt  <= bus.hdr_data[15:8];
      end else if (w_pay_ren) begin
        r_cnt  <= r_cnt - 8'd1;
      end
      if (r_state == S_DECODE)   r_sel <= w_match;
      else if (w_next == S_IDLE) r_sel <= 3'b000;
    end
  end

  // hdr_ren is combinational from IDLE, so hold it low while reset is applied
  assign bus.hdr_ren    = w_hdr_ren && rst_n;
  assign bus.pay_ren    = w_pay_ren;
  assign bus.port_wen   = r_wen;
  assign bus.port_sel   = r_sel;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.drop_pulse = r_drop_pulse;
endmodule
